fifo_drain_packer: RTL and testbench
====================================

# fifo_drain_packer

Read-side controller for the team's synchronous FIFO. It issues `fifo_rd_enb` against the FIFO's `empty` flag and captures the registered read data, which arrives one cycle after the read. It packs `PACK` consecutive `WIDTH`-bit entries into one word on a valid/ready output stream. A flush request emits a partial word with a lane mask, so the last bytes of a message are never stranded in the packer.

## Interface
Parameters:
- `WIDTH`, 8: FIFO entry width in bits.
- `PACK`, 4: entries per output word; must be ≥2.
- `CNT_W`, 3: width of the fill and lane counters; must satisfy 2^CNT_W > PACK.

Ports:
- `clock`  in  1  clock; all state updates on its rising edge.
- `resetn`  in  1  reset; synchronous, active-low.
- `fifo_empty`  in  1  FIFO empty flag.
- `fifo_rd_enb`  out  1  FIFO read request; combinational.
- `fifo_data`  in  WIDTH  FIFO read data; valid in the cycle after an accepted read.
- `flush`  in  1  single-cycle request to emit any partially filled word.
- `out_data`  out  WIDTH*PACK  packed word; lane 0 is bits [WIDTH-1:0] and holds the oldest entry.
- `out_keep`  out  PACK  lane-valid mask; contiguous from lane 0.
- `out_valid`  out  1  output word valid.
- `out_ready`  in  1  downstream accepts the word.
- `busy`  out  1  high while `fill`≠0, `inflight`, `flush_pending`, or `out_valid`.

## Operation
Internal state:
- `asm`: assembly register, WIDTH*PACK bits.
- `fill`: 0..PACK.
- `inflight`: 1 bit.
- `flush_pending`: 1 bit.
- FSM with states COLLECT and FLUSH.

Definitions:
- `slot_free` = ~`out_valid` | `out_ready`.
- `word_done` = `inflight` & (`fill`==PACK-1) & `slot_free`.

Read issue:
- `fifo_rd_enb` = `resetn` & ~`fifo_empty` & (state==COLLECT) & ((`fill`+`inflight` < PACK) | `word_done`).
- `inflight` takes the value of `fifo_rd_enb` on every edge.

Capture (when `inflight`):
- `fifo_data` is written to lane `fill`, and `fill` increments.
- If `word_done`, the full word {`fifo_data`, asm lanes 0..PACK-2} loads `out_data` directly. On the same edge: `out_keep`=all ones, `out_valid`=1, `fill`=0.

Stalled word:
- If `fill`==PACK and `slot_free`, `asm` transfers to the output, `out_keep`=all ones, and `fill`=0.
- Reads are blocked in that cycle.

Output handshake:
- A word transfers when `out_valid` & `out_ready`.
- While `out_valid` & ~`out_ready`, `out_data` and `out_keep` are held stable.

Flush:
- `flush` in COLLECT moves the FSM to FLUSH. No new reads are issued.
- In FLUSH, after `inflight` clears: if `fill`>0 and `slot_free`, emit `asm` with lanes ≥`fill` zeroed and `out_keep` = (1<<`fill`)-1, then set `fill`=0. If `fill`==0, emit nothing.
- FLUSH then returns to COLLECT.
- `flush` asserted while already in FLUSH is ignored.

Reset:
- All registers clear: `out_valid`=0, `out_data`=0, `out_keep`=0, `fill`=0, `inflight`=0, state=COLLECT.
- A partial word or in-flight entry is discarded; the FIFO is reset by the same `resetn`.

## Timing
- Read accepted at edge N: its data is captured at edge N+1.
- A word's last entry read at edge N: `out_valid` rises after edge N+1.
- Sustained throughput with `out_ready`=1 and a non-empty FIFO is one entry per cycle, i.e. one word every PACK cycles, with no bubbles.
- Backpressure costs at most one idle read cycle per stalled word.
- After `resetn` rises, `fifo_rd_enb` may assert in the first cycle.
- Flush latency:
  - Flush with no read in flight: partial word valid 1 cycle after `flush`.
  - Flush with a read in flight: partial word valid 2 cycles after `flush`; the in-flight entry is included.

## Structure
- Shared package: FSM state enum (COLLECT, FLUSH) and the keep-mask function (fill → mask).
- One sub-module, `word_out_slot`: the output register with its valid/ready hold logic (`out_data`, `out_keep`, `out_valid`, `slot_free`).
- Read issue, capture, and flush control stay in the top level.

## Test plan
All scenarios use WIDTH=8, PACK=4.
- Reset: hold `resetn`=0 for 3 cycles with a non-empty FIFO → `fifo_rd_enb`=0, `out_valid`=0, `out_data`=0, `out_keep`=0 throughout.
- Streaming: FIFO holds 0x11..0x88, `out_ready`=1 → `fifo_rd_enb` high 8 consecutive cycles. Words 0x44332211 then 0x88776655 are output 4 cycles apart, each with `out_keep`=4'b1111.
- Backpressure: 12 entries, `out_ready`=0 → first word held stable, second word fills `asm`, `fifo_rd_enb` drops to 0. Release `out_ready` → three words in order, no loss or duplication.
- Flush partial: FIFO holds 0xA1, 0xA2, 0xA3 then goes empty; pulse `flush` → `out_data`=0x00A3A2A1, `out_keep`=4'b0111. A second `flush` with `fill`=0 → no word.
- Flush during read: pulse `flush` in the cycle after the third entry's read → that entry is included and the partial word is valid 2 cycles after `flush`.
- Mid-word reset: assert `resetn`=0 with `fill`=2 → `out_valid` stays 0. After reset, a fresh 4-entry word packs from lane 0 with no stale lanes.

Source files
------------

// File: rtl/fifo_drain_packer_pkg.sv
// Shared types and helpers for the FIFO drain packer.
// Holds the controller state encoding and the fill-to-lane-mask helper.
package fifo_drain_packer_pkg;

   typedef enum logic [0:0] {
      ST_COLLECT = 1'b0,
      ST_FLUSH   = 1'b1
   } drain_state_t;

   localparam int MAX_PACK = 32;

   // Lanes below fill are valid; the mask is always contiguous from lane 0.
   function automatic logic [MAX_PACK-1:0] keep_mask(input int fill);
      logic [MAX_PACK-1:0] m;
      m = '0;
      for (int i = 0; i < MAX_PACK; i++) begin
         if (i < fill) m[i] = 1'b1;
      end
      return m;
   endfunction

endpackage

// File: rtl/word_out_slot.sv
// Output word register for the drain packer: holds data/keep stable while
// the downstream stalls and reports when a new word may be loaded.
module word_out_slot #(
   parameter int WORD_W = 32,
   parameter int PACK   = 4
) (
   input  logic              clock,
   input  logic              resetn,
   input  logic              load,
   input  logic [WORD_W-1:0] load_data,
   input  logic [PACK-1:0]   load_keep,
   input  logic              out_ready,
   output logic [WORD_W-1:0] out_data,
   output logic [PACK-1:0]   out_keep,
   output logic              out_valid,
   output logic              slot_free
);

   assign slot_free = !out_valid || out_ready;

   always_ff @(posedge clock) begin
      if (!resetn) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_keep  <= '0;
      end else if (load) begin
         out_valid <= 1'b1;
         out_data  <= load_data;
         out_keep  <= load_keep;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: rtl/fifo_drain_packer.sv
// Read-side controller for the synchronous FIFO: drains entries, packs PACK
// of them per output word, and emits a masked partial word on flush.
//
//   state      | meaning
//   COLLECT    | issue reads while the FIFO has data and a lane is available
//   FLUSH      | reads stopped; wait for the in-flight entry, then emit partial
module fifo_drain_packer
   import fifo_drain_packer_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int PACK  = 4,
   parameter int CNT_W = 3
) (
   input  logic                  clock,
   input  logic                  resetn,
   input  logic                  fifo_empty,
   output logic                  fifo_rd_enb,
   input  logic [WIDTH-1:0]      fifo_data,
   input  logic                  flush,
   output logic [WIDTH*PACK-1:0] out_data,
   output logic [PACK-1:0]       out_keep,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  busy
);

   localparam int WORD_W = WIDTH * PACK;

   drain_state_t        state;
   logic [WORD_W-1:0]   asm_word;
   logic [CNT_W-1:0]    fill;
   logic                inflight;
   logic                flush_pending;

   logic                slot_free;
   logic                word_done;
   logic                fill_full;
   logic                lane_room;
   logic                flush_active;
   logic                flush_emit;
   logic                stall_emit;
   logic                load;
   logic [WORD_W-1:0]   load_data;
   logic [PACK-1:0]     load_keep;
   logic [PACK-1:0]     lane_keep;

   assign fill_full  = (fill == CNT_W'(PACK));
   assign word_done  = inflight && (fill == CNT_W'(PACK-1)) && slot_free;
   assign lane_room  = ({1'b0, fill} + {{CNT_W{1'b0}}, inflight}) < (CNT_W+1)'(PACK);

   // A flush seen in COLLECT acts on the same edge when nothing is in flight,
   // which is what gives the one-cycle partial-word latency.
   assign flush_active = (state == ST_FLUSH) || (state == ST_COLLECT && flush);
   assign flush_emit   = flush_active && !inflight && (fill != '0) && slot_free;
   assign stall_emit   = fill_full && slot_free;
   assign load         = word_done || stall_emit || flush_emit;

   assign fifo_rd_enb = resetn && !fifo_empty && (state == ST_COLLECT) && !flush &&
                        (lane_room || word_done);

   assign busy = (fill != '0) || inflight || flush_pending || out_valid;

   assign lane_keep = PACK'(keep_mask(int'(fill)));

   always_comb begin
      load_keep = '1;
      load_data = {fifo_data, asm_word[WORD_W-WIDTH-1:0]};
      if (!word_done) begin
         load_keep = lane_keep;
         for (int l = 0; l < PACK; l++) begin
            load_data[l*WIDTH +: WIDTH] = lane_keep[l] ? asm_word[l*WIDTH +: WIDTH] : '0;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (!resetn) begin
         state         <= ST_COLLECT;
         asm_word      <= '0;
         fill          <= '0;
         inflight      <= 1'b0;
         flush_pending <= 1'b0;
      end else begin
         inflight <= fifo_rd_enb;

         if (inflight) begin
            for (int l = 0; l < PACK; l++) begin
               if (fill == CNT_W'(l)) asm_word[l*WIDTH +: WIDTH] <= fifo_data;
            end
            fill <= word_done ? '0 : fill + CNT_W'(1);
         end else if (stall_emit || flush_emit) begin
            fill <= '0;
         end

         case (state)
            ST_COLLECT: begin
               if (flush && !flush_emit && (inflight || fill != '0)) begin
                  state         <= ST_FLUSH;
                  flush_pending <= 1'b1;
               end
            end
            ST_FLUSH: begin
               if (!inflight && (fill == '0 || slot_free)) begin
                  state         <= ST_COLLECT;
                  flush_pending <= 1'b0;
               end
            end
            default: begin
               state         <= ST_COLLECT;
               flush_pending <= 1'b0;
            end
         endcase
      end
   end

   word_out_slot #(
      .WORD_W (WORD_W),
      .PACK   (PACK)
   ) u_slot (
      .clock     (clock),
      .resetn    (resetn),
      .load      (load),
      .load_data (load_data),
      .load_keep (load_keep),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_keep  (out_keep),
      .out_valid (out_valid),
      .slot_free (slot_free)
   );

endmodule

// File: tb/tb_fifo_drain_packer.sv
// Directed bench for fifo_drain_packer: a queue-based packing model predicts
// every transferred word, with literal checks on latency and specific words.
module tb_fifo_drain_packer;

   localparam int WIDTH = 8;
   localparam int PACK  = 4;
   localparam int CNT_W = 3;

   logic                  clock = 1'b0;
   logic                  resetn;
   logic                  fifo_empty;
   logic                  fifo_rd_enb;
   logic [WIDTH-1:0]      fifo_data = '0;
   logic                  flush;
   logic [WIDTH*PACK-1:0] out_data;
   logic [PACK-1:0]       out_keep;
   logic                  out_valid;
   logic                  out_ready;
   logic                  busy;

   int checks   = 0;
   int failures = 0;

   always #5 clock = ~clock;

   fifo_drain_packer #(.WIDTH(WIDTH), .PACK(PACK), .CNT_W(CNT_W)) dut (
      .clock       (clock),
      .resetn      (resetn),
      .fifo_empty  (fifo_empty),
      .fifo_rd_enb (fifo_rd_enb),
      .fifo_data   (fifo_data),
      .flush       (flush),
      .out_data    (out_data),
      .out_keep    (out_keep),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .busy        (busy)
   );

   // Bench FIFO: registered read data, one cycle after an accepted read.
   logic [WIDTH-1:0] fifo_mem [0:255];
   int wr_ptr = 0;
   int rd_ptr = 0;
   assign fifo_empty = (rd_ptr == wr_ptr);

   always @(posedge clock) begin
      if (fifo_rd_enb) begin
         fifo_data <= fifo_mem[rd_ptr];
         rd_ptr    <= rd_ptr + 1;
      end
   end

   // Packing model: entries accumulate in order; every PACK entries form a
   // full word, a flush closes whatever is pending, a reset discards it.
   typedef struct {
      logic [31:0] data;
      logic [3:0]  keep;
   } word_t;

   word_t      exp_q[$];
   logic [7:0] pend[$];

   task automatic emit_pending();
      word_t w;
      w.data = '0;
      w.keep = '0;
      foreach (pend[i]) begin
         w.data = w.data | (32'(pend[i]) << (8 * i));
         w.keep[i] = 1'b1;
      end
      exp_q.push_back(w);
      pend.delete();
   endtask

   task automatic push_entry(input logic [7:0] v);
      fifo_mem[wr_ptr] = v;
      wr_ptr++;
      pend.push_back(v);
      if (pend.size() == PACK) emit_pending();
   endtask

   task automatic model_flush();
      if (pend.size() > 0) emit_pending();
   endtask

   task automatic model_reset();
      pend.delete();
   endtask

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Compare process: every transfer against the model, plus hold stability.
   logic        prev_valid = 1'b0;
   logic        prev_ready = 1'b0;
   logic [31:0] prev_data  = '0;
   logic [3:0]  prev_keep  = '0;
   int          words_seen = 0;

   always @(negedge clock) begin
      if (resetn === 1'b1) begin
         if (prev_valid && !prev_ready) begin
            check("hold_valid", 64'(out_valid), 64'd1);
            check("hold_data", 64'(out_data), 64'(prev_data));
            check("hold_keep", 64'(out_keep), 64'(prev_keep));
         end
         if (out_valid === 1'b1 && out_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_word: got %h keep %b, expected no word", out_data, out_keep);
            end else begin
               word_t w;
               w = exp_q.pop_front();
               check("word_data", 64'(out_data), 64'(w.data));
               check("word_keep", 64'(out_keep), 64'(w.keep));
            end
            words_seen++;
         end
      end
      prev_valid = (resetn === 1'b1) && (out_valid === 1'b1);
      prev_ready = out_ready;
      prev_data  = out_data;
      prev_keep  = out_keep;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [11:0] rd_vec;
      logic [11:0] val_vec;
      logic [31:0] w1;
      logic [31:0] w2;
      int          ws0;
      int          n;
      int          got;

      resetn    = 1'b0;
      flush     = 1'b0;
      out_ready = 1'b1;

      for (int i = 1; i <= 8; i++) push_entry(8'(i * 16 + i));
      check("model_words", 64'(exp_q.size()), 64'd2);
      check("model_w1", 64'(exp_q[0].data), 64'h44332211);
      check("model_w2", 64'(exp_q[1].data), 64'h88776655);

      // Reset held with a non-empty FIFO.
      repeat (3) begin
         @(posedge clock);
         @(negedge clock);
         check("rst_rd_enb", 64'(fifo_rd_enb), 64'd0);
         check("rst_valid", 64'(out_valid), 64'd0);
         check("rst_data", 64'(out_data), 64'd0);
         check("rst_keep", 64'(out_keep), 64'd0);
      end

      // Streaming: reads start in the first cycle after reset.
      @(posedge clock);
      #1 resetn = 1'b1;
      rd_vec  = '0;
      val_vec = '0;
      w1 = '0;
      w2 = '0;
      for (int k = 1; k <= 12; k++) begin
         @(negedge clock);
         rd_vec[k-1]  = fifo_rd_enb;
         val_vec[k-1] = out_valid;
         if (k == 6)  w1 = out_data;
         if (k == 10) w2 = out_data;
      end
      check("stream_rd_enb", 64'(rd_vec), 64'h0FF);
      check("stream_valid_cycles", 64'(val_vec), 64'h220);
      check("stream_w1", 64'(w1), 64'h44332211);
      check("stream_w2", 64'(w2), 64'h88776655);

      // Backpressure: 12 entries, downstream stalled.
      @(posedge clock);
      #1 out_ready = 1'b0;
      for (int i = 0; i < 12; i++) push_entry(8'(8'hC0 + i));
      repeat (20) @(negedge clock);
      check("bp_valid", 64'(out_valid), 64'd1);
      check("bp_data", 64'(out_data), 64'hC3C2C1C0);
      check("bp_keep", 64'(out_keep), 64'hF);
      check("bp_rd_enb", 64'(fifo_rd_enb), 64'd0);
      check("bp_fifo_left", 64'(wr_ptr - rd_ptr), 64'd4);
      check("bp_busy", 64'(busy), 64'd1);
      ws0 = words_seen;
      @(posedge clock);
      #1 out_ready = 1'b1;
      for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(negedge clock);
      repeat (3) @(negedge clock);
      check("bp_words", 64'(words_seen - ws0), 64'd3);
      check("bp_drained", 64'(exp_q.size()), 64'd0);

      // Flush of a 3-entry partial word with nothing in flight.
      @(posedge clock);
      #1;
      push_entry(8'hA1);
      push_entry(8'hA2);
      push_entry(8'hA3);
      repeat (8) @(negedge clock);
      check("fp_idle_valid", 64'(out_valid), 64'd0);
      check("fp_idle_busy", 64'(busy), 64'd1);
      @(posedge clock);
      #1 flush = 1'b1;
      model_flush();
      @(negedge clock);
      check("fp_lat0_valid", 64'(out_valid), 64'd0);
      @(posedge clock);
      #1 flush = 1'b0;
      @(negedge clock);
      check("fp_lat1_valid", 64'(out_valid), 64'd1);
      check("fp_data", 64'(out_data), 64'h00A3A2A1);
      check("fp_keep", 64'(out_keep), 64'h7);

      // Second flush with nothing pending emits no word.
      @(posedge clock);
      #1 flush = 1'b1;
      @(posedge clock);
      #1 flush = 1'b0;
      got = 0;
      repeat (4) begin
         @(negedge clock);
         if (out_valid) got = 1;
      end
      check("fp2_no_word", 64'(got), 64'd0);
      check("fp2_busy", 64'(busy), 64'd0);

      // Flush while the third entry is still in flight.
      @(posedge clock);
      #1;
      push_entry(8'hB1);
      push_entry(8'hB2);
      push_entry(8'hB3);
      n = 0;
      for (int i = 0; i < 20 && n < 3; i++) begin
         @(negedge clock);
         if (fifo_rd_enb) n++;
      end
      check("fr_reads", 64'(n), 64'd3);
      @(posedge clock);
      #1 flush = 1'b1;
      model_flush();
      @(negedge clock);
      check("fr_lat0_valid", 64'(out_valid), 64'd0);
      @(posedge clock);
      #1 flush = 1'b0;
      @(negedge clock);
      check("fr_lat1_valid", 64'(out_valid), 64'd0);
      @(negedge clock);
      check("fr_lat2_valid", 64'(out_valid), 64'd1);
      check("fr_data", 64'(out_data), 64'h00B3B2B1);
      check("fr_keep", 64'(out_keep), 64'h7);

      // Reset with two entries packed; they must not surface afterwards.
      @(posedge clock);
      #1;
      push_entry(8'hD1);
      push_entry(8'hD2);
      n = 0;
      for (int i = 0; i < 20 && n < 2; i++) begin
         @(negedge clock);
         if (fifo_rd_enb) n++;
      end
      check("mr_reads", 64'(n), 64'd2);
      repeat (2) @(negedge clock);
      check("mr_busy", 64'(busy), 64'd1);
      @(posedge clock);
      #1 resetn = 1'b0;
      model_reset();
      repeat (3) begin
         @(negedge clock);
         check("mr_rst_valid", 64'(out_valid), 64'd0);
      end
      @(posedge clock);
      #1 resetn = 1'b1;
      push_entry(8'hE1);
      push_entry(8'hE2);
      push_entry(8'hE3);
      push_entry(8'hE4);
      got = 0;
      for (int i = 0; i < 20 && got == 0; i++) begin
         @(negedge clock);
         if (out_valid) begin
            got = 1;
            check("mr_data", 64'(out_data), 64'hE4E3E2E1);
            check("mr_keep", 64'(out_keep), 64'hF);
         end
      end
      check("mr_word_seen", 64'(got), 64'd1);

      repeat (5) @(negedge clock);
      check("end_model_empty", 64'(exp_q.size()), 64'd0);
      check("end_busy", 64'(busy), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
